// File: rtl/key_pkg.sv
// Shared types and defaults for the multi-channel key debouncer.
package key_pkg;

    // Per-channel press-tracking states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } key_st_e;

    // Raw pin polarity selectors
    localparam bit POL_ACTIVE_LOW  = 1'b1;
    localparam bit POL_ACTIVE_HIGH = 1'b0;

    // Default geometry (~22 ms debounce at 12 MHz)
    localparam int unsigned DEF_N_KEYS    = 4;
    localparam int unsigned DEF_CNT_W     = 18;
    localparam int unsigned DEF_LONG_W    = 24;
    localparam int unsigned DEF_REPEAT_W  = 21;
    localparam bit          DEF_REPEAT_EN = 1'b1;

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pins in, debounced levels and event pulses out.
interface key_debounce_multi_if
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS = DEF_N_KEYS
);

    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_down;
    logic [N_KEYS-1:0] key_up;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_rpt;
    logic              key_any;

    // Board / stimulus side
    modport master (
        output key_in,
        input  key_state, key_down, key_up, key_long, key_rpt, key_any
    );

    // Debouncer side
    modport slave (
        input  key_in,
        output key_state, key_down, key_up, key_long, key_rpt, key_any
    );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, debounce counter, press FSM, long-press and repeat timers.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned LONG_W     = DEF_LONG_W,
    parameter int unsigned REPEAT_W   = DEF_REPEAT_W,
    parameter bit          REPEAT_EN  = DEF_REPEAT_EN,
    parameter bit          ACTIVE_LOW = POL_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_key_state,
    output logic o_key_down,
    output logic o_key_up,
    output logic o_key_long,
    output logic o_key_rpt,
    output logic o_key_state_nxt_c
);

    logic                w_pressed;
    logic                r_s0;
    logic                r_s1;
    logic [CNT_W-1:0]    r_dcnt;
    logic                r_state;
    logic                w_toggle;
    logic                w_rise;
    logic                w_fall;

    key_st_e             r_fsm;
    key_st_e             w_fsm_nxt;
    logic [LONG_W-1:0]   r_hcnt;
    logic [LONG_W-1:0]   w_hcnt_nxt;
    logic [REPEAT_W-1:0] r_rcnt;
    logic [REPEAT_W-1:0] w_rcnt_nxt;
    logic                r_down;
    logic                r_up;
    logic                r_long;
    logic                r_rpt;
    logic                w_down_nxt;
    logic                w_up_nxt;
    logic                w_long_nxt;
    logic                w_rpt_nxt;

    assign w_pressed = ACTIVE_LOW ? ~i_key : i_key;

    // Two-flop synchroniser; reset holds the released level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= w_pressed;
            r_s1 <= r_s0;
        end
    end

    assign w_toggle          = (r_s1 != r_state) && (r_dcnt == '1);
    assign w_rise            = w_toggle && !r_state;
    assign w_fall            = w_toggle &&  r_state;
    assign o_key_state_nxt_c = r_state ^ w_toggle;

    // Debounce: a new level must persist for a full counter period before it is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dcnt  <= '0;
            r_state <= 1'b0;
        end else begin
            if (r_s1 == r_state || w_toggle) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + CNT_W'(1);
            end
            r_state <= o_key_state_nxt_c;
        end
    end

    // FSM state, timers and registered pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm  <= ST_IDLE;
            r_hcnt <= '0;
            r_rcnt <= '0;
            r_down <= 1'b0;
            r_up   <= 1'b0;
            r_long <= 1'b0;
            r_rpt  <= 1'b0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_hcnt <= w_hcnt_nxt;
            r_rcnt <= w_rcnt_nxt;
            r_down <= w_down_nxt;
            r_up   <= w_up_nxt;
            r_long <= w_long_nxt;
            r_rpt  <= w_rpt_nxt;
        end
    end

    // Next-state and pulse decode; a debounced release overrides everything
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_hcnt_nxt = r_hcnt;
        w_rcnt_nxt = r_rcnt;
        w_down_nxt = w_rise;
        w_up_nxt   = w_fall;
        w_long_nxt = 1'b0;
        w_rpt_nxt  = w_rise;

        if (w_fall) begin
            w_fsm_nxt  = ST_IDLE;
            w_hcnt_nxt = '0;
            w_rcnt_nxt = '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_fsm_nxt  = ST_PRESSED;
                        w_hcnt_nxt = '0;
                        w_rcnt_nxt = '0;
                    end
                end
                ST_PRESSED: begin
                    if (r_hcnt == '1) begin
                        w_fsm_nxt  = ST_LONG;
                        w_long_nxt = 1'b1;
                        w_rcnt_nxt = '0;
                    end else begin
                        w_hcnt_nxt = r_hcnt + LONG_W'(1);
                    end
                end
                ST_LONG: begin
                    w_rcnt_nxt = r_rcnt + REPEAT_W'(1);
                    if (REPEAT_EN && r_rcnt == '1) begin
                        w_rpt_nxt = 1'b1;
                    end
                end
                default: begin
                    w_fsm_nxt  = ST_IDLE;
                    w_hcnt_nxt = '0;
                    w_rcnt_nxt = '0;
                end
            endcase
        end
    end

    assign o_key_state = r_state;
    assign o_key_down  = r_down;
    assign o_key_up    = r_up;
    assign o_key_long  = r_long;
    assign o_key_rpt   = r_rpt;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent debounced key channels plus a combined any-key-held flag.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS     = DEF_N_KEYS,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned LONG_W     = DEF_LONG_W,
    parameter int unsigned REPEAT_W   = DEF_REPEAT_W,
    parameter bit          REPEAT_EN  = DEF_REPEAT_EN,
    parameter bit          ACTIVE_LOW = POL_ACTIVE_LOW
) (
    input logic                  clk,
    input logic                  rst,
    key_debounce_multi_if.slave  kbus
);

    logic [N_KEYS-1:0] w_state;
    logic [N_KEYS-1:0] w_down;
    logic [N_KEYS-1:0] w_up;
    logic [N_KEYS-1:0] w_long;
    logic [N_KEYS-1:0] w_rpt;
    logic [N_KEYS-1:0] w_state_nxt;
    logic              r_key_any;

    // One channel instance per key
    for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch
        key_debounce_ch #(
            .CNT_W      (CNT_W),
            .LONG_W     (LONG_W),
            .REPEAT_W   (REPEAT_W),
            .REPEAT_EN  (REPEAT_EN),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk               (clk),
            .rst               (rst),
            .i_key             (kbus.key_in[g]),
            .o_key_state       (w_state[g]),
            .o_key_down        (w_down[g]),
            .o_key_up          (w_up[g]),
            .o_key_long        (w_long[g]),
            .o_key_rpt         (w_rpt[g]),
            .o_key_state_nxt_c (w_state_nxt[g])
        );
    end

    // Any-key flag built from next-state levels so it lines up with key_state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_any <= 1'b0;
        end else begin
            r_key_any <= |w_state_nxt;
        end
    end

    assign kbus.key_state = w_state;
    assign kbus.key_down  = w_down;
    assign kbus.key_up    = w_up;
    assign kbus.key_long  = w_long;
    assign kbus.key_rpt   = w_rpt;
    assign kbus.key_any   = r_key_any;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: scenario tasks checked against a sliding-window event model.
module tb_key_debounce_multi;
    import key_pkg::*;

    localparam int unsigned NK   = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned LW   = 6;
    localparam int unsigned RW   = 3;
    localparam bit          REN  = 1'b1;
    localparam bit          ALOW = POL_ACTIVE_LOW;
    localparam int DEB_N  = 1 << CW;   // stable samples needed
    localparam int DEB    = DEB_N + 2; // change-to-level latency
    localparam int LONG_T = 1 << LW;
    localparam int RPT_T  = 1 << RW;
    localparam int MAXC   = 16384;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_debounce_multi_if #(.N_KEYS(NK)) kb();

    key_debounce_multi #(
        .N_KEYS(NK), .CNT_W(CW), .LONG_W(LW), .REPEAT_W(RW),
        .REPEAT_EN(REN), .ACTIVE_LOW(ALOW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .kbus (kb)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rst = 0;

    bit          m_hist [NK][MAXC];
    bit [NK-1:0] m_state, e_down, e_up, e_long, e_rpt;
    bit          e_any;
    int          press_t [NK];
    logic [5*NK:0] obs, exp;

    // Advance one clock and update the model from the levels presented at that edge
    task automatic tick();
        bit old;
        bit flip;
        int dt;
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        e_down = '0; e_up = '0; e_long = '0; e_rpt = '0;
        if (!rst) begin
            last_rst = cyc;
            m_state  = '0;
            for (int ch = 0; ch < NK; ch++) m_hist[ch][cyc] = 1'b0;
        end else begin
            for (int ch = 0; ch < NK; ch++) begin
                m_hist[ch][cyc] = ALOW ? !kb.key_in[ch] : kb.key_in[ch];
                old  = m_state[ch];
                flip = (cyc - last_rst >= DEB);
                if (flip) begin
                    for (int j = 0; j < DEB_N; j++)
                        if (m_hist[ch][cyc-2-j] == old) flip = 1'b0;
                end
                if (flip) begin
                    m_state[ch] = !old;
                    if (old) e_up[ch] = 1'b1;
                    else begin
                        e_down[ch]  = 1'b1;
                        press_t[ch] = cyc;
                    end
                end
                if (m_state[ch]) begin
                    dt = cyc - press_t[ch];
                    e_long[ch] = (dt == LONG_T);
                    e_rpt[ch]  = e_down[ch] ||
                                 (REN && dt > LONG_T && ((dt - LONG_T) % RPT_T) == 0);
                end
            end
        end
        e_any = |m_state;
        exp = {m_state, e_down, e_up, e_long, e_rpt, e_any};
        #1;
        obs = {kb.key_state, kb.key_down, kb.key_up, kb.key_long, kb.key_rpt, kb.key_any};
    endtask

    task automatic test_reset();
        int t_rel, n_down, t_down;
        rst = 1'b0;
        kb.key_in = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", cyc, obs, {(5*NK+1){1'b0}});
            end
        end
        rst = 1'b1;
        t_rel = cyc; n_down = 0; t_down = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (kb.key_down[0] === 1'b1) begin n_down++; t_down = cyc; end
        end
        checks++;
        if (t_down - t_rel != DEB) begin
            errors++;
            $display("FAIL reset_down_latency got=%0d exp=%0d", t_down - t_rel, DEB);
        end
        checks++;
        if (n_down != 1) begin
            errors++;
            $display("FAIL reset_down_pulses got=%0d exp=1", n_down);
        end
        kb.key_in = 2'b11;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_release_keys cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_glitch();
        int n_hi;
        n_hi = 0;
        kb.key_in[0] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) kb.key_in[0] = 1'b1;
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (kb.key_state[0] !== 1'b0 || kb.key_down[0] !== 1'b0 || kb.key_up[0] !== 1'b0) n_hi++;
        end
        checks++;
        if (n_hi != 0) begin
            errors++;
            $display("FAIL glitch_activity got=%0d exp=0", n_hi);
        end
    endtask

    task automatic test_clean_press();
        int t0, t1, t_down, t_long, t_up, n_rpt;
        t_down = -1; t_long = -1; t_up = -1; n_rpt = 0;
        t0 = cyc;
        kb.key_in[0] = 1'b0;
        for (int i = 0; i < 140; i++) begin
            if (i == 100) begin kb.key_in[0] = 1'b1; t1 = cyc; end
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (kb.key_down[0] === 1'b1) t_down = cyc;
            if (kb.key_long[0] === 1'b1) t_long = cyc;
            if (kb.key_up[0]   === 1'b1) t_up   = cyc;
            if (kb.key_rpt[0]  === 1'b1) n_rpt++;
        end
        checks++;
        if (t_down - t0 != DEB) begin
            errors++;
            $display("FAIL clean_down_latency got=%0d exp=%0d", t_down - t0, DEB);
        end
        checks++;
        if (t_long - t0 != DEB + LONG_T) begin
            errors++;
            $display("FAIL clean_long_latency got=%0d exp=%0d", t_long - t0, DEB + LONG_T);
        end
        checks++;
        if (n_rpt != 5) begin
            errors++;
            $display("FAIL clean_rpt_count got=%0d exp=5", n_rpt);
        end
        checks++;
        if (t_up - t1 != DEB) begin
            errors++;
            $display("FAIL clean_up_latency got=%0d exp=%0d", t_up - t1, DEB);
        end
    endtask

    task automatic test_bounce();
        int t_last, t_up, n_up;
        t_up = -1; n_up = 0;
        kb.key_in[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bounce_press cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
        end
        for (int k = 0; k < 8; k++) begin
            kb.key_in[0] = (k % 2 == 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL bounce_toggle cyc=%0d got=%b exp=%b", cyc, obs, exp);
                end
                if (kb.key_up[0] === 1'b1) n_up++;
            end
        end
        kb.key_in[0] = 1'b1;
        t_last = cyc;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bounce_settle cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (kb.key_up[0] === 1'b1) begin n_up++; t_up = cyc; end
        end
        checks++;
        if (n_up != 1) begin
            errors++;
            $display("FAIL bounce_up_count got=%0d exp=1", n_up);
        end
        checks++;
        if (t_up - t_last != DEB) begin
            errors++;
            $display("FAIL bounce_up_latency got=%0d exp=%0d", t_up - t_last, DEB);
        end
    endtask

    task automatic test_simultaneous();
        int n_both, n_single, t_any, t_state;
        n_both = 0; n_single = 0; t_any = -1; t_state = -1;
        kb.key_in = 2'b00;
        for (int i = 0; i < 60; i++) begin
            if (i == 30) kb.key_in = 2'b11;
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (kb.key_down === 2'b11) n_both++;
            if (kb.key_down === 2'b01 || kb.key_down === 2'b10) n_single++;
            if (t_any < 0 && kb.key_any === 1'b1) t_any = cyc;
            if (t_state < 0 && kb.key_state === 2'b11) t_state = cyc;
        end
        checks++;
        if (n_both != 1 || n_single != 0) begin
            errors++;
            $display("FAIL simul_down both=%0d single=%0d exp both=1 single=0", n_both, n_single);
        end
        checks++;
        if (t_any != t_state || t_any < 0) begin
            errors++;
            $display("FAIL simul_any_align any=%0d state=%0d", t_any, t_state);
        end
    endtask

    task automatic test_reset_long();
        int t_rel, t_down, t_long;
        t_down = -1; t_long = -1;
        kb.key_in[0] = 1'b0;
        for (int i = 0; i < 90; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_long_hold cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL rst_long_zero cyc=%0d got=%b exp=0", cyc, obs);
            end
        end
        rst = 1'b1;
        t_rel = cyc;
        for (int i = 0; i < 130; i++) begin
            if (i == 100) kb.key_in[0] = 1'b1;
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_long_after cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
            if (t_down < 0 && kb.key_down[0] === 1'b1) t_down = cyc;
            if (t_long < 0 && kb.key_long[0] === 1'b1) t_long = cyc;
        end
        checks++;
        if (t_down - t_rel != DEB) begin
            errors++;
            $display("FAIL rst_long_down got=%0d exp=%0d", t_down - t_rel, DEB);
        end
        checks++;
        if (t_long - t_rel != DEB + LONG_T) begin
            errors++;
            $display("FAIL rst_long_long got=%0d exp=%0d", t_long - t_rel, DEB + LONG_T);
        end
    endtask

    task automatic test_random();
        int ch, hold;
        for (int s = 0; s < 40; s++) begin
            ch   = int'($urandom_range(0, NK - 1));
            hold = int'($urandom_range(1, 110));
            kb.key_in[ch] = ~kb.key_in[ch];
            for (int i = 0; i < hold; i++) begin
                tick();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp);
                end
            end
        end
        kb.key_in = 2'b11;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_release cyc=%0d got=%b exp=%b", cyc, obs, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        kb.key_in = 2'b00;
        test_reset();
        test_glitch();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_long();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
